omsp_sha512_msg_padder: RTL and testbench
=========================================

Name: omsp_sha512_msg_padder

Overview:
Message-padding stage for the SHA-512 path. It accepts the 32-bit message words produced by the frontend's 16-to-32 packing, together with a byte count and an end-of-message flag. It emits the fully padded SHA-512 message as 32-bit words to the compression core: data, then 0x80, then zero fill, then the 128-bit big-endian bit length. Every message becomes a whole number of 1024-bit (32-word) blocks, delivered over a valid/ready stream.

Parameters:
LEN_W, 64, width of the internal message bit-length counter (legal 32..64). Length-field bits above LEN_W are emitted as zero.

Ports:
clk  input  1  block clock
rst  input  1  synchronous, active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  upstream word accepted when in_valid && in_ready
in_data  input  32  message word, big-endian (byte 0 = bits 31:24)
in_bytes  input  3  valid bytes in in_data, MSB-first; 1..4, or 0 only with in_last
in_last  input  1  final word of message
out_valid  output  1  padded word valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_data  output  32  padded message word
out_block_start  output  1  out_data is word 0 of a 1024-bit block
out_msg_last  output  1  out_data is word 31 of the final block
busy  output  1  message in progress
err  output  1  sticky protocol error flag

Behaviour:
- Reset is sampled on posedge clk while rst==0.
  - Reset values: out_valid=0, out_data=0, out_block_start=0, out_msg_last=0, busy=0, err=0.
  - Internal state: state=DATA, word index=0, bit length=0.
  - Reset mid-message discards everything. No partial block is emitted afterwards.
- Output register holds a single entry. Every output word is registered, so data reaches out_data 1 cycle after the input handshake.
  - out_data, out_block_start and out_msg_last hold stable while out_valid && !out_ready.
  - A new word may load in the same cycle the old word is taken.
- Word index: 5-bit, incremented on every out_data load, wraps 31->0. out_block_start = (index of held word == 0).
- Bit length: on each accepted input, len += 8*in_bytes, modulo 2^LEN_W.
- States:
  - DATA: in_ready = (!out_valid || out_ready).
    - Non-last word: load in_data unchanged.
    - Last word with in_bytes=n, 0..3: load in_data with byte n set to 0x80 and bytes after n cleared. Next state ZERO.
    - Last word with in_bytes=4: load in_data unchanged. Next state PAD80.
  - PAD80: in_ready=0. Load 0x80000000. Next state ZERO.
  - ZERO: in_ready=0.
    - While the next index != 28, load 0x00000000.
    - When the next index == 28, go to LEN without loading.
    - Consequence: if the 0x80 word landed at index 28..31, zero fill runs through index 27 of an additional block.
  - LEN: in_ready=0. Load four words, MSB-first: len[127:96], len[95:64], len[63:32], len[31:0], with bits >= LEN_W forced to 0.
    - The index 31 word sets out_msg_last=1.
    - After that load: next state DATA, len=0, index=0.
- busy:
  - Set on the first accepted input of a message.
  - Cleared when the out_msg_last word handshakes.
  - busy=1 also holds through DATA while a message is open.
- Protocol errors set err (sticky until reset); the word is still processed:
  - in_bytes<4 without in_last: treat as in_bytes=4.
  - in_bytes=0 without in_last: treat as in_bytes=4.
  - in_bytes>4: treat as 4.
- Simultaneous events:
  - The last input and the downstream take of the previous word in one cycle are both honoured.
  - in_valid during PAD80/ZERO/LEN is ignored (no handshake).

Test Plan:
- Empty message: in_bytes=0, in_last=1, data=0.
  - Required: 32 words. Word0=0x80000000, words 1..31=0. out_block_start on word0, out_msg_last on word31.
- "abc": in_data=0x61626300, in_bytes=3, in_last=1.
  - Required: word0=0x61626380, words 1..30=0, word31=0x00000018. busy falls after word31 handshake.
- 112-byte message: 28 full words, last with in_bytes=4.
  - Required: 64 output words. Word28=0x80000000, words 29..59=0, words 60..62=0, word63=0x00000380.
  - out_block_start on words 0 and 32; out_msg_last only on word63.
- Backpressure: 5-word message with out_ready random 50%.
  - Required: exactly 32 words, no loss or duplication, out_data stable while stalled.
  - in_ready=0 whenever out_valid && !out_ready.
- Reset mid-LEN: assert rst=0 for 1 cycle after word29 is loaded.
  - Required: next cycle out_valid=0, busy=0. The following "abc" message produces the exact "abc" output.
- Protocol error: in_bytes=2 with in_last=0, then a valid last word.
  - Required: err=1 and stays 1. The word is counted as 4 bytes.

Source files
------------

// File: rtl/omsp_sha512_msg_padder.sv
// omsp_sha512_msg_padder: SHA-512 message padding (0x80, zero fill, 128-bit length) over a 32-bit valid/ready stream.
module omsp_sha512_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_block_start,
    output logic        out_msg_last,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {DATA, PAD80, ZERO, LEN} state_t;
    state_t state;
    logic [4:0] idx;
    logic [LEN_W-1:0] len;
    logic load_ok, take, bad, ld;
    logic [2:0] eff;
    logic [127:0] len128;
    logic [31:0] last_word, len_word, nxt;
    assign load_ok = !out_valid || out_ready;
    assign in_ready = state == DATA && load_ok;
    assign take = in_valid && in_ready;
    // Malformed byte counts are counted as a full word and flagged.
    assign bad = in_bytes > 3'd4 || (!in_last && in_bytes != 3'd4);
    assign eff = bad ? 3'd4 : in_bytes;
    assign last_word = (in_data & ~(32'hFFFF_FFFF >> {eff, 3'b0})) | (32'h8000_0000 >> {eff, 3'b0});
    assign len128 = 128'(len);
    assign len_word = len128[{~idx[1:0], 5'b0} +: 32];
    always_comb begin
        ld = load_ok && (state == DATA ? in_valid : state == ZERO ? idx != 5'd28 : 1'b1);
        nxt = state == DATA ? ((in_last && eff != 3'd4) ? last_word : in_data) :
              state == PAD80 ? 32'h8000_0000 :
              state == ZERO ? 32'h0 : len_word;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DATA;
            idx <= '0;
            len <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_block_start <= 1'b0;
            out_msg_last <= 1'b0;
            busy <= 1'b0;
            err <= 1'b0;
        end else begin
            if (out_valid && out_ready && out_msg_last)
                busy <= 1'b0;
            if (ld) begin
                out_valid <= 1'b1;
                out_data <= nxt;
                out_block_start <= idx == 5'd0;
                out_msg_last <= state == LEN && idx == 5'd31;
                idx <= idx + 5'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                DATA: if (take) begin
                    len <= len + LEN_W'({eff, 3'b0});
                    busy <= 1'b1;
                    err <= err | bad;
                    if (in_last)
                        state <= eff == 3'd4 ? PAD80 : ZERO;
                end
                PAD80: if (ld) state <= ZERO;
                ZERO: if (idx == 5'd28) state <= LEN;
                LEN: if (ld && idx == 5'd31) begin
                    state <= DATA;
                    len <= '0;
                end
                default: state <= DATA;
            endcase
        end
    end
endmodule

// File: tb/tb_omsp_sha512_msg_padder.sv
// tb_omsp_sha512_msg_padder: randomized scoreboard bench against a byte-level SHA-512 padding model.
module tb_omsp_sha512_msg_padder;
    logic clk = 0, rst = 0;
    logic in_valid = 0, in_ready, in_last = 0;
    logic [31:0] in_data = 0, out_data;
    logic [2:0] in_bytes = 0;
    logic out_valid, out_ready = 1, out_block_start, out_msg_last, busy, err;
    int checks = 0, errors = 0, hs_cnt = 0;
    bit bp = 0, stall = 0;
    logic [33:0] held;
    logic [33:0] q[$];
    logic [31:0] wq[$];

    omsp_sha512_msg_padder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_bytes(in_bytes), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_block_start(out_block_start), .out_msg_last(out_msg_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always begin
        @(posedge clk);
        #1 out_ready = bp ? 1'($urandom % 2) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst && stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({out_block_start, out_msg_last, out_data}), 64'(held));
        end
        if (rst && out_valid && !out_ready)
            chk("in_ready_stall", 64'(in_ready), 64'd0);
        if (rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %h expected none", out_data);
            end else begin
                chk($sformatf("word%0d", hs_cnt), 64'({out_block_start, out_msg_last, out_data}), 64'(q.pop_front()));
            end
            hs_cnt++;
        end
        stall = rst && out_valid && !out_ready;
        held = {out_block_start, out_msg_last, out_data};
    end

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic l);
        bit hs = 0;
        in_valid = 1; in_data = d; in_bytes = nb; in_last = l;
        for (int n = 0; n < 2000 && !hs; n++) begin
            @(negedge clk) hs = in_ready;
            @(posedge clk);
            #1;
        end
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL in_handshake_timeout: got no accept expected accept");
        end
        in_valid = 0;
    endtask

    // Reference: pad the message as a byte string, then cut into 32-bit words.
    task automatic send_msg(input int lb, input bit bad_first);
        logic [7:0] m[$];
        logic [31:0] wd;
        logic [127:0] bl;
        int eff, total;
        for (int i = 0; i < wq.size(); i++) begin
            wd = wq[i];
            eff = (i == wq.size() - 1) ? lb : 4;
            for (int b = 0; b < eff; b++) m.push_back(wd[31 - 8*b -: 8]);
        end
        bl = 128'(m.size()) * 128'd8;
        m.push_back(8'h80);
        while (m.size() % 128 != 112) m.push_back(8'h00);
        for (int b = 15; b >= 0; b--) m.push_back(bl[8*b +: 8]);
        total = m.size() / 4;
        for (int i = 0; i < total; i++)
            q.push_back({i % 32 == 0, i == total - 1, m[4*i], m[4*i+1], m[4*i+2], m[4*i+3]});
        for (int i = 0; i < wq.size(); i++)
            send_word(wq[i], i == wq.size() - 1 ? 3'(lb) : (bad_first && i == 0) ? 3'd2 : 3'd4, i == wq.size() - 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        int base, n;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_bs", 64'(out_block_start), 64'd0);
        chk("rst_ml", 64'(out_msg_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        wq = {32'h0};
        send_msg(0, 0);
        drain("empty");
        wq = {32'h61626300};
        send_msg(3, 0);
        drain("abc");
        rand_words(28);
        send_msg(4, 0);
        drain("m112");
        bp = 1;
        rand_words(5);
        send_msg($urandom_range(1, 4), 0);
        drain("bp5");
        for (int k = 0; k < 6; k++) begin
            rand_words($urandom_range(1, 40));
            send_msg($urandom_range(0, 4), 0);
            drain("rand");
        end
        bp = 0;
        @(posedge clk);
        #1;
        base = hs_cnt;
        wq = {32'h61626300};
        send_msg(3, 0);
        n = 0;
        while (hs_cnt != base + 29 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_mid_reach", 64'(hs_cnt), 64'(base + 29));
        rst = 0;
        @(posedge clk);
        #1 rst = 1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        q.delete();
        wq = {32'h61626300};
        send_msg(3, 0);
        drain("abc2");
        chk("err_clean", 64'(err), 64'd0);
        bp = 1;
        rand_words(3);
        send_msg($urandom_range(0, 4), 1);
        drain("proto");
        chk("err_set", 64'(err), 64'd1);
        rand_words(2);
        send_msg(4, 0);
        drain("post_err");
        chk("err_sticky", 64'(err), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
